snitch_amo_bank_arbiter: RTL and testbench

- Shares one AMO-capable SRAM bank shim between NumCores core request ports and one DMA port.
- DMA has priority, limited by a starvation counter; cores are served round-robin, with the grant locked while the shim stalls (AMO in flight).
- Routes the one-cycle-delayed read data back to the accepted requester with a per-port response valid.
- Sits between the cluster interconnect and the bank shim, one instance per bank.

---
 rtl/snitch_amo_pkg.sv | 19 +
 rtl/snitch_amo_bank_arbiter.sv | 169 ++++++++++++++++
 tb/tb_snitch_amo_bank_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_amo_pkg.sv
// rtl/snitch_amo_pkg.sv - AMO operation encoding shared by the bank arbiter, its shim and requesters
package snitch_amo_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

endpackage

// File: rtl/snitch_amo_bank_arbiter.sv
// rtl/snitch_amo_bank_arbiter.sv - DMA-priority / core round-robin arbiter in front of one AMO bank shim
module snitch_amo_bank_arbiter
  import snitch_amo_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumCores     = 4,
  parameter int unsigned DmaMaxBurst  = 8,
  parameter int unsigned CoreIDWidth  = $clog2(NumCores),
  parameter int unsigned StrbWidth    = DataWidth / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumCores-1:0]               core_valid_i,
  output logic [NumCores-1:0]               core_ready_o,
  input  logic [NumCores*AddrMemWidth-1:0]  core_addr_i,
  input  amo_op_e [NumCores-1:0]            core_amo_i,
  input  logic [NumCores-1:0]               core_write_i,
  input  logic [NumCores*DataWidth-1:0]     core_wdata_i,
  input  logic [NumCores*StrbWidth-1:0]     core_wstrb_i,
  output logic [NumCores-1:0]               core_rvalid_o,
  input  logic                              dma_valid_i,
  output logic                              dma_ready_o,
  input  logic [AddrMemWidth-1:0]           dma_addr_i,
  input  logic                              dma_write_i,
  input  logic [DataWidth-1:0]              dma_wdata_i,
  input  logic [StrbWidth-1:0]              dma_wstrb_i,
  output logic                              dma_rvalid_o,
  output logic [DataWidth-1:0]              rdata_o,
  output logic                              shim_valid_o,
  input  logic                              shim_ready_i,
  output logic                              shim_dma_access_o,
  output logic [AddrMemWidth-1:0]           shim_addr_o,
  output amo_op_e                           shim_amo_o,
  output logic                              shim_write_o,
  output logic [DataWidth-1:0]              shim_wdata_o,
  output logic [StrbWidth-1:0]              shim_wstrb_o,
  output logic [CoreIDWidth-1:0]            shim_core_id_o,
  output logic                              shim_is_core_o,
  input  logic [DataWidth-1:0]              shim_rdata_i
);

  localparam int unsigned CntWidth = $clog2(DmaMaxBurst + 1);

  logic                   lock_q, lock_d;
  logic [CoreIDWidth-1:0] lock_id_q, lock_id_d;
  logic [CoreIDWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]    dma_cnt_q, dma_cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_dma_q, resp_dma_d;
  logic [CoreIDWidth-1:0] resp_id_q, resp_id_d;

  logic                   rr_found;
  logic [CoreIDWidth-1:0] rr_idx;
  logic [CoreIDWidth:0]   cand;
  logic [CoreIDWidth-1:0] win_id;
  logic                   any_core_valid, dma_sel, core_sel, dma_hs, core_hs;

  // Round-robin search: first valid core at or after rr_ptr, wrapping at NumCores-1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr_q;
    cand     = '0;
    for (int unsigned i = 0; i < NumCores; i++) begin
      cand = {1'b0, rr_ptr_q} + (CoreIDWidth + 1)'(i);
      if (cand >= (CoreIDWidth + 1)'(NumCores)) begin
        cand = cand - (CoreIDWidth + 1)'(NumCores);
      end
      if (!rr_found && core_valid_i[cand[CoreIDWidth-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[CoreIDWidth-1:0];
      end
    end
  end

  always_comb begin
    any_core_valid    = |core_valid_i;
    dma_sel           = dma_valid_i && !(any_core_valid && (dma_cnt_q == CntWidth'(DmaMaxBurst)));
    win_id            = lock_q ? lock_id_q : rr_idx;
    core_sel          = !dma_sel && (lock_q || rr_found);
    shim_valid_o      = dma_valid_i || any_core_valid || lock_q;
    core_ready_o      = '0;
    dma_ready_o       = 1'b0;
    shim_dma_access_o = 1'b0;
    shim_is_core_o    = 1'b0;
    shim_core_id_o    = '0;
    shim_addr_o       = '0;
    shim_amo_o        = AMONone;
    shim_write_o      = 1'b0;
    shim_wdata_o      = '0;
    shim_wstrb_o      = '0;
    if (dma_sel) begin
      dma_ready_o       = shim_ready_i;
      shim_dma_access_o = 1'b1;
      shim_addr_o       = dma_addr_i;
      shim_write_o      = dma_write_i;
      shim_wdata_o      = dma_wdata_i;
      shim_wstrb_o      = dma_wstrb_i;
    end else if (core_sel) begin
      core_ready_o[win_id] = shim_ready_i;
      shim_is_core_o       = 1'b1;
      shim_core_id_o       = win_id;
      shim_addr_o          = core_addr_i[win_id*AddrMemWidth +: AddrMemWidth];
      shim_amo_o           = core_amo_i[win_id];
      shim_write_o         = core_write_i[win_id];
      shim_wdata_o         = core_wdata_i[win_id*DataWidth +: DataWidth];
      shim_wstrb_o         = core_wstrb_i[win_id*StrbWidth +: StrbWidth];
    end
    dma_hs  = dma_sel && shim_ready_i;
    core_hs = core_sel && shim_ready_i;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    dma_cnt_d    = dma_cnt_q;
    resp_valid_d = dma_hs || core_hs;
    resp_dma_d   = dma_hs;
    resp_id_d    = core_hs ? win_id : '0;
    if (core_hs) begin
      rr_ptr_d = (win_id == CoreIDWidth'(NumCores - 1)) ? '0 : win_id + 1'b1;
      lock_d   = 1'b0;
    end else if (core_sel) begin
      // A stalled core keeps the grant until its AMO/access is taken.
      lock_d    = 1'b1;
      lock_id_d = win_id;
    end
    if (core_hs || !any_core_valid) begin
      dma_cnt_d = '0;
    end else if (dma_hs && (dma_cnt_q != CntWidth'(DmaMaxBurst))) begin
      dma_cnt_d = dma_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      dma_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_dma_q   <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      rr_ptr_q     <= rr_ptr_d;
      dma_cnt_q    <= dma_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_dma_q   <= resp_dma_d;
      resp_id_q    <= resp_id_d;
    end
  end

  always_comb begin
    core_rvalid_o = '0;
    if (resp_valid_q && !resp_dma_q) begin
      core_rvalid_o[resp_id_q] = 1'b1;
    end
    dma_rvalid_o = resp_valid_q && resp_dma_q;
    rdata_o      = shim_rdata_i;
  end

  locked_core_holds_request: assert property (
    @(posedge clk_i) disable iff (!rst_ni) lock_q |-> core_valid_i[lock_id_q]
  );

endmodule

// File: tb/tb_snitch_amo_bank_arbiter.sv
// tb/tb_snitch_amo_bank_arbiter.sv - vector-table and sequence checks for snitch_amo_bank_arbiter
module tb_snitch_amo_bank_arbiter;
  import snitch_amo_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int NC = 4;
  localparam int SW = DW / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NC-1:0]       core_valid = '0;
  logic [NC-1:0]       core_ready;
  logic [NC*AW-1:0]    core_addr;
  amo_op_e [NC-1:0]    core_amo;
  logic [NC-1:0]       core_write;
  logic [NC*DW-1:0]    core_wdata;
  logic [NC*SW-1:0]    core_wstrb;
  logic [NC-1:0]       core_rvalid;
  logic                dma_valid = 1'b0;
  logic                dma_ready;
  logic [AW-1:0]       dma_addr = 32'h0000_8000;
  logic                dma_write = 1'b1;
  logic [DW-1:0]       dma_wdata = 64'hD3A0_D3A0_1234_5678;
  logic [SW-1:0]       dma_wstrb = 8'hF0;
  logic                dma_rvalid;
  logic [DW-1:0]       rdata;
  logic                shim_valid;
  logic                shim_ready = 1'b0;
  logic                shim_dma_access;
  logic [AW-1:0]       shim_addr;
  amo_op_e             shim_amo;
  logic                shim_write;
  logic [DW-1:0]       shim_wdata;
  logic [SW-1:0]       shim_wstrb;
  logic [1:0]          shim_core_id;
  logic                shim_is_core;
  logic [DW-1:0]       shim_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] m_addr  [NC];
  logic [DW-1:0] m_wdata [NC];
  amo_op_e       m_amo   [NC];
  logic          m_write [NC];

  typedef struct {
    logic [3:0] cv;
    logic       dv;
    logic       rdy;
    logic [3:0] e_cready;
    logic       e_dready;
    logic [3:0] e_crv;
    logic       e_drv;
    logic       e_sv;
    logic       e_dma;
    logic       e_core;
    logic [1:0] e_id;
  } vec_t;

  vec_t tbl[15];

  snitch_amo_bank_arbiter dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .core_valid_i     (core_valid),
    .core_ready_o     (core_ready),
    .core_addr_i      (core_addr),
    .core_amo_i       (core_amo),
    .core_write_i     (core_write),
    .core_wdata_i     (core_wdata),
    .core_wstrb_i     (core_wstrb),
    .core_rvalid_o    (core_rvalid),
    .dma_valid_i      (dma_valid),
    .dma_ready_o      (dma_ready),
    .dma_addr_i       (dma_addr),
    .dma_write_i      (dma_write),
    .dma_wdata_i      (dma_wdata),
    .dma_wstrb_i      (dma_wstrb),
    .dma_rvalid_o     (dma_rvalid),
    .rdata_o          (rdata),
    .shim_valid_o     (shim_valid),
    .shim_ready_i     (shim_ready),
    .shim_dma_access_o(shim_dma_access),
    .shim_addr_o      (shim_addr),
    .shim_amo_o       (shim_amo),
    .shim_write_o     (shim_write),
    .shim_wdata_o     (shim_wdata),
    .shim_wstrb_o     (shim_wstrb),
    .shim_core_id_o   (shim_core_id),
    .shim_is_core_o   (shim_is_core),
    .shim_rdata_i     (shim_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, check combinational outputs 1ns later, advance to next negedge.
  task automatic apply(input string tag, input vec_t v);
    logic [DW-1:0] rd;
    rd = {$urandom, $urandom};
    core_valid = v.cv;
    dma_valid  = v.dv;
    shim_ready = v.rdy;
    shim_rdata = rd;
    #1;
    chk({tag, ".core_ready"},  64'(core_ready),  64'(v.e_cready));
    chk({tag, ".dma_ready"},   64'(dma_ready),   64'(v.e_dready));
    chk({tag, ".core_rvalid"}, 64'(core_rvalid), 64'(v.e_crv));
    chk({tag, ".dma_rvalid"},  64'(dma_rvalid),  64'(v.e_drv));
    chk({tag, ".shim_valid"},  64'(shim_valid),  64'(v.e_sv));
    if ((v.e_crv != 4'b0) || v.e_drv) chk({tag, ".rdata"}, rdata, rd);
    if (v.e_dma) begin
      chk({tag, ".dma_access"}, 64'(shim_dma_access), 64'd1);
      chk({tag, ".dma_is_core"}, 64'(shim_is_core), 64'd0);
      chk({tag, ".dma_amo"},    64'(shim_amo),  64'(AMONone));
      chk({tag, ".dma_addr"},   64'(shim_addr), 64'(32'h0000_8000));
      chk({tag, ".dma_wdata"},  shim_wdata,     64'hD3A0_D3A0_1234_5678);
    end
    if (v.e_core) begin
      chk({tag, ".is_core"},    64'(shim_is_core),    64'd1);
      chk({tag, ".core_access"}, 64'(shim_dma_access), 64'd0);
      chk({tag, ".core_id"},    64'(shim_core_id),    64'(v.e_id));
      chk({tag, ".core_addr"},  64'(shim_addr),       64'(m_addr[v.e_id]));
      chk({tag, ".core_amo"},   64'(shim_amo),        64'(m_amo[v.e_id]));
      chk({tag, ".core_write"}, 64'(shim_write),      64'(m_write[v.e_id]));
      chk({tag, ".core_wdata"}, shim_wdata,           m_wdata[v.e_id]);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [3:0] cv, input logic dv, input logic rdy,
                              input logic [3:0] ecr, input logic edr, input logic [3:0] ecrv,
                              input logic edrv, input logic esv, input logic edma,
                              input logic ecore, input logic [1:0] eid);
    vec_t v;
    v.cv = cv; v.dv = dv; v.rdy = rdy;
    v.e_cready = ecr; v.e_dready = edr; v.e_crv = ecrv; v.e_drv = edrv;
    v.e_sv = esv; v.e_dma = edma; v.e_core = ecore; v.e_id = eid;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < NC; i++) begin
      m_addr[i]  = 32'h100 + 32'(i);
      m_wdata[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
      m_write[i] = i[0];
      m_amo[i]   = (i == 1) ? AMOAdd : ((i == 2) ? AMOSwap : AMONone);
      core_addr[i*AW +: AW]  = m_addr[i];
      core_wdata[i*DW +: DW] = m_wdata[i];
      core_wstrb[i*SW +: SW] = 8'hFF;
      core_write[i]          = m_write[i];
      core_amo[i]            = m_amo[i];
    end

    //             cv      dv  rdy  cready  drdy crv    drv sv  dma core id
    tbl[0]  = mk(4'b0101, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 0, 1, 2'd0);
    tbl[1]  = mk(4'b0100, 0, 1, 4'b0100, 0, 4'b0001, 0, 1, 0, 1, 2'd2);
    tbl[2]  = mk(4'b0000, 0, 1, 4'b0000, 0, 4'b0100, 0, 0, 0, 0, 2'd0);
    tbl[3]  = mk(4'b1111, 0, 1, 4'b1000, 0, 4'b0000, 0, 1, 0, 1, 2'd3);
    tbl[4]  = mk(4'b1111, 0, 1, 4'b0001, 0, 4'b1000, 0, 1, 0, 1, 2'd0);
    tbl[5]  = mk(4'b1111, 0, 1, 4'b0010, 0, 4'b0001, 0, 1, 0, 1, 2'd1);
    tbl[6]  = mk(4'b1111, 0, 1, 4'b0100, 0, 4'b0010, 0, 1, 0, 1, 2'd2);
    tbl[7]  = mk(4'b1111, 0, 1, 4'b1000, 0, 4'b0100, 0, 1, 0, 1, 2'd3);
    tbl[8]  = mk(4'b1111, 0, 1, 4'b0001, 0, 4'b1000, 0, 1, 0, 1, 2'd0);
    tbl[9]  = mk(4'b1010, 0, 0, 4'b0000, 0, 4'b0001, 0, 1, 0, 1, 2'd1);
    tbl[10] = mk(4'b1010, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 1, 2'd1);
    tbl[11] = mk(4'b1010, 0, 1, 4'b0010, 0, 4'b0000, 0, 1, 0, 1, 2'd1);
    tbl[12] = mk(4'b1000, 0, 1, 4'b1000, 0, 4'b0010, 0, 1, 0, 1, 2'd3);
    tbl[13] = mk(4'b0000, 1, 1, 4'b0000, 1, 4'b1000, 0, 1, 1, 0, 2'd0);
    tbl[14] = mk(4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 2'd0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("reset.core_ready",  64'(core_ready),  64'd0);
    chk("reset.dma_ready",   64'(dma_ready),   64'd0);
    chk("reset.core_rvalid", 64'(core_rvalid), 64'd0);
    chk("reset.dma_rvalid",  64'(dma_rvalid),  64'd0);
    chk("reset.shim_valid",  64'(shim_valid),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // DMA burst against a waiting core0: 8 DMA grants, core0, 8 DMA grants, core0.
    for (int i = 0; i < 18; i++) begin
      logic cg, prev_cg;
      cg      = (i == 8) || (i == 17);
      prev_cg = (i == 9);
      apply($sformatf("burst[%0d]", i),
            mk(4'b0001, 1, 1, cg ? 4'b0001 : 4'b0000, !cg, prev_cg ? 4'b0001 : 4'b0000,
               (i > 0) && !prev_cg, 1, !cg, cg, 2'd0));
    end
    apply("burst.tail", mk(4'b0000, 0, 1, 4'b0000, 0, 4'b0001, 0, 0, 0, 0, 2'd0));

    // DMA slips through core2's stalled AMO; lock then beats round-robin choice of core1.
    apply("lockdma[0]", mk(4'b0100, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 1, 2'd2));
    apply("lockdma[1]", mk(4'b0100, 1, 1, 4'b0000, 1, 4'b0000, 0, 1, 1, 0, 2'd0));
    apply("lockdma[2]", mk(4'b0110, 0, 1, 4'b0100, 0, 4'b0000, 1, 1, 0, 1, 2'd2));
    apply("lockdma[3]", mk(4'b0010, 0, 1, 4'b0010, 0, 4'b0100, 0, 1, 0, 1, 2'd1));
    apply("lockdma[4]", mk(4'b0000, 0, 1, 4'b0000, 0, 4'b0010, 0, 0, 0, 0, 2'd0));

    // Reset while core3 is locked and a DMA response is pending.
    apply("rst[0]", mk(4'b1000, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 1, 2'd3));
    apply("rst[1]", mk(4'b1000, 1, 1, 4'b0000, 1, 4'b0000, 0, 1, 1, 0, 2'd0));
    #1;
    chk("rst.pending_dma_rvalid", 64'(dma_rvalid), 64'd1);
    rst_n      = 1'b0;
    core_valid = '0;
    dma_valid  = 1'b0;
    #1;
    chk("rst.async_dma_rvalid",  64'(dma_rvalid),  64'd0);
    chk("rst.async_core_rvalid", 64'(core_rvalid), 64'd0);
    @(posedge clk);
    #1;
    chk("rst.held_dma_rvalid",   64'(dma_rvalid),  64'd0);
    chk("rst.held_core_rvalid",  64'(core_rvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("rst[2]", mk(4'b1001, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 0, 1, 2'd0));
    apply("rst[3]", mk(4'b1000, 0, 1, 4'b1000, 0, 4'b0001, 0, 1, 0, 1, 2'd3));
    apply("rst[4]", mk(4'b0000, 0, 1, 4'b0000, 0, 4'b1000, 0, 0, 0, 0, 2'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
